// File: rtl/led_pwm.sv
// LED brightness/blink stage: gates active-low GPIO lines with a per-channel 8-bit PWM duty
// and an optional blink envelope, driving active-low LED pins. Bus-mapped DUTY/BLINK/STATUS.
`timescale 1ns/1ps
module led_pwm #(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] q,
  input  logic [3:0]  gpio_in,
  output logic [3:0]  led
);

  localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_TC    = PW'(PRESCALE - 1);
  localparam logic [7:0]    PWM_LAST  = 8'd254;
  localparam logic [7:0]    ADDR_DUTY = 8'h00;
  localparam logic [7:0]    ADDR_BLNK = 8'h04;
  localparam logic [7:0]    ADDR_STAT = 8'h08;

  logic [PW-1:0] presc;
  logic [7:0]    pwm_cnt;
  logic          step;
  logic          wrap;

  logic [31:0]   duty_shadow;
  logic [31:0]   duty_active;
  logic [15:0]   half_period;
  logic [3:0]    blink_en;
  logic [15:0]   blink_cnt;
  logic          phase;

  logic          wr_duty;
  logic          wr_blink;
  logic [3:0]    on;

  assign step     = (presc == PRE_TC);
  assign wrap     = step && (pwm_cnt == PWM_LAST);
  assign wr_duty  = we && (addr == ADDR_DUTY);
  assign wr_blink = we && (addr == ADDR_BLNK) && (be != 4'b0000);

  // Prescaler and PWM counter; the period is 255 steps so duty 255 is always on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (step) begin
      presc   <= '0;
      pwm_cnt <= wrap ? 8'd0 : pwm_cnt + 8'd1;
    end else begin
      presc   <= presc + PW'(1);
    end
  end

  // The active duty samples the shadow as it stood before any same-edge write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_shadow <= '1;
      duty_active <= '1;
    end else begin
      if (wrap) begin
        duty_active <= duty_shadow;
      end
      if (wr_duty) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            duty_shadow[8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_period <= '0;
      blink_en    <= '0;
    end else if (we && (addr == ADDR_BLNK)) begin
      if (be[0]) half_period[7:0]  <= wdata[7:0];
      if (be[1]) half_period[15:8] <= wdata[15:8];
      if (be[2]) blink_en          <= wdata[19:16];
    end
  end

  // A BLINK write restarts the envelope lit, taking priority over a coincident wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (wr_blink || (half_period == 16'd0)) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (wrap) begin
      if (blink_cnt == half_period - 16'd1) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    on = '0;
    for (int n = 0; n < 4; n++) begin
      on[n] = ~gpio_in[n] & (pwm_cnt < duty_active[8*n +: 8]) & (~blink_en[n] | phase);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= 4'hF;
    end else begin
      led <= ~on;
    end
  end

  always_comb begin
    q = '0;
    case (addr)
      ADDR_DUTY: q = duty_shadow;
      ADDR_BLNK: q = {12'h000, blink_en, half_period};
      ADDR_STAT: q = {16'h0000, pwm_cnt, 4'h0, on};
      default:   q = '0;
    endcase
  end

endmodule
